uvma_clk_gen: RTL

Programmable, glitch-free clock generator that sits directly upstream of the clock agent interface. It produces the clock driven onto the interface, so the interface assertions always see a clock with defined, well-formed edges. The bench sequencer controls it through a valid/ready command port to start, stop and re-period the clock. The generated clock is derived by counting cycles of the single reference clock.

---
 rtl/uvma_clk_gen.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uvma_clk_gen.sv
// Programmable glitch-free clock generator for the clock agent interface.
// The generated clock is produced by counting reference-clock cycles; it is controlled over a valid/ready command port.
module uvma_clk_gen #(
    parameter int HP_WIDTH            = 16,
    parameter int CNT_WIDTH           = 32,
    parameter int DEFAULT_HALF_PERIOD = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [HP_WIDTH-1:0]  cmd_half_period,
    output logic                 gen_clk,
    output logic                 gen_clk_running,
    output logic [CNT_WIDTH-1:0] rise_count,
    output logic                 cfg_error
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_STOP_PEND = 2'd2
    } state_t;

    localparam logic [1:0] OP_START      = 2'd0;
    localparam logic [1:0] OP_STOP       = 2'd1;
    localparam logic [1:0] OP_SET_PERIOD = 2'd2;
    localparam logic [1:0] OP_RSVD       = 2'd3;

    localparam logic [HP_WIDTH-1:0]  HP_RESET = HP_WIDTH'(DEFAULT_HALF_PERIOD);
    localparam logic [HP_WIDTH-1:0]  HP_ONE   = HP_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_t               state, state_nxt;
    logic                 gen_clk_nxt;
    logic [HP_WIDTH-1:0]  phase_cnt, phase_cnt_nxt;
    logic [HP_WIDTH-1:0]  hp_active, hp_active_nxt;
    logic [HP_WIDTH-1:0]  hp_pending, hp_pending_nxt;
    logic [CNT_WIDTH-1:0] rise_count_nxt;
    logic                 cfg_error_nxt;
    logic                 accept, cmd_bad, cmd_ok, phase_end;

    assign cmd_ready       = (state != ST_STOP_PEND);
    assign gen_clk_running = (state == ST_RUN);

    assign accept    = cmd_valid && cmd_ready;
    assign cmd_bad   = accept && ((cmd_op == OP_RSVD) ||
                                  ((cmd_op == OP_SET_PERIOD) && (cmd_half_period == '0)));
    assign cmd_ok    = accept && !cmd_bad;
    assign phase_end = (phase_cnt == (hp_active - HP_ONE));

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_nxt      = state;
        gen_clk_nxt    = gen_clk;
        phase_cnt_nxt  = phase_cnt;
        hp_active_nxt  = hp_active;
        hp_pending_nxt = hp_pending;
        rise_count_nxt = rise_count;
        cfg_error_nxt  = cmd_bad;

        unique case (state)
            ST_IDLE: begin
                gen_clk_nxt   = 1'b0;
                phase_cnt_nxt = '0;
                if (cmd_ok && (cmd_op == OP_START)) begin
                    state_nxt      = ST_RUN;
                    gen_clk_nxt    = 1'b1;
                    rise_count_nxt = rise_count + CNT_ONE;
                    hp_active_nxt  = hp_pending;
                end else if (cmd_ok && (cmd_op == OP_SET_PERIOD)) begin
                    hp_active_nxt  = cmd_half_period;
                    hp_pending_nxt = cmd_half_period;
                end
            end

            ST_RUN: begin
                if (phase_end) begin
                    gen_clk_nxt   = !gen_clk;
                    phase_cnt_nxt = '0;
                    // A new half-period is adopted only at a rising edge.
                    if (!gen_clk) begin
                        rise_count_nxt = rise_count + CNT_ONE;
                        hp_active_nxt  = hp_pending;
                    end
                end else begin
                    phase_cnt_nxt = phase_cnt + HP_ONE;
                end

                if (cmd_ok && (cmd_op == OP_SET_PERIOD)) begin
                    hp_pending_nxt = cmd_half_period;
                end

                if (cmd_ok && (cmd_op == OP_STOP)) begin
                    if (gen_clk && !phase_end) begin
                        state_nxt = ST_STOP_PEND;
                    end else begin
                        // Low phase is truncated, or the high phase ends on this very edge; no rise follows.
                        state_nxt      = ST_IDLE;
                        gen_clk_nxt    = 1'b0;
                        phase_cnt_nxt  = '0;
                        rise_count_nxt = rise_count;
                        hp_active_nxt  = hp_active;
                    end
                end
            end

            ST_STOP_PEND: begin
                if (phase_end) begin
                    state_nxt     = ST_IDLE;
                    gen_clk_nxt   = 1'b0;
                    phase_cnt_nxt = '0;
                end else begin
                    phase_cnt_nxt = phase_cnt + HP_ONE;
                end
            end

            default: begin
                state_nxt     = ST_IDLE;
                gen_clk_nxt   = 1'b0;
                phase_cnt_nxt = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset drops gen_clk without a clk edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            gen_clk    <= 1'b0;
            phase_cnt  <= '0;
            hp_active  <= HP_RESET;
            hp_pending <= HP_RESET;
            rise_count <= '0;
            cfg_error  <= 1'b0;
        end else begin
            state      <= state_nxt;
            gen_clk    <= gen_clk_nxt;
            phase_cnt  <= phase_cnt_nxt;
            hp_active  <= hp_active_nxt;
            hp_pending <= hp_pending_nxt;
            rise_count <= rise_count_nxt;
            cfg_error  <= cfg_error_nxt;
        end
    end

endmodule
